mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle datapath's memory requests (MemRead/MemWrite/IorD-selected address).
//  Accepts one read or write at a time, drives a synchronous single-port SRAM with programmable wait states,
//  and returns ReadData plus a one-cycle MemReady/MemError completion strobe to the control unit.
//  Sits between the datapath address/data muxes and the unified instruction/data SRAM.
// PARAMETERS
//  DATA_W       16      data word width
//  ADDR_W       16      word-address width from datapath
//  MEM_WORDS    1024    implemented SRAM words; Addr >= MEM_WORDS is an error
//  WAIT_STATES  1       extra cycles before SRAM access, legal 0..15
// PORTS
//  CLK        in   1        clock, all logic on rising edge
//  Reset      in   1        synchronous, active-low reset
//  MemRead    in   1        read request from control unit
//  MemWrite   in   1        write request from control unit
//  Addr       in   ADDR_W   word address (datapath IorD mux output)
//  WriteData  in   DATA_W   store data
//  ReadData   out  DATA_W   read result, valid when MemReady & ~MemError for a read
//  MemReady   out  1        one-cycle completion strobe (also fires on error)
//  MemError   out  1        one-cycle strobe with MemReady: illegal request
//  MemBusy    out  1        high from accept until cycle after completion strobe
//  sram_en    out  1        SRAM enable, one cycle per access
//  sram_we    out  1        SRAM write enable (only with sram_en)
//  sram_addr  out  $clog2(MEM_WORDS)  SRAM address
//  sram_wdata out  DATA_W   SRAM write data
//  sram_rdata in   DATA_W   SRAM read data, valid cycle after sram_en&~sram_we
// BEHAVIOUR
//  Reset (Reset==0 at edge): state IDLE; ReadData, MemReady, MemError, MemBusy, sram_en, sram_we, sram_addr,
//   sram_wdata, wait counter all 0. Reset mid-operation aborts: no SRAM access issued after the reset edge.
//  States: IDLE, WAIT, ACCESS, RESP, ERR.
//  IDLE: if MemRead^MemWrite and Addr<MEM_WORDS -> latch op/Addr/WriteData, counter=WAIT_STATES,
//   go WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES==0). MemBusy=1 from next cycle.
//   If MemRead&MemWrite, or either asserted with Addr>=MEM_WORDS -> ERR. Neither -> stay IDLE.
//  WAIT: decrement counter; when counter==1 -> ACCESS. Exactly WAIT_STATES cycles spent in WAIT.
//  ACCESS: sram_en=1, sram_we=latched write, sram_addr/sram_wdata from latches (registered outputs) -> RESP.
//  RESP: MemReady=1 one cycle; on read ReadData<=sram_rdata captured at the RESP entry edge+1 and held
//   until next successful read completes; writes and errors never change ReadData -> IDLE.
//  ERR: MemReady=1, MemError=1 for one cycle, no sram_en -> IDLE.
//  Latency: request seen in IDLE at cycle 0 -> MemReady high in cycle WAIT_STATES+2; ERR -> cycle 1.
//  Request inputs are ignored outside IDLE (no queueing). A request still held in the IDLE cycle after
//   completion is accepted as a new request; control unit must drop MemRead/MemWrite on MemReady.
//  Address truncation: sram_addr = latched Addr[$clog2(MEM_WORDS)-1:0]; range check uses full ADDR_W.
//  Counter width $clog2(16)=4 bits; no wrap possible within legal WAIT_STATES.
//  Outputs are registered; no combinational path from request inputs to any output.
// STRUCTURE
//  Shared package mem_resp_pkg: state encoding (IDLE=0,WAIT=1,ACCESS=2,RESP=3,ERR=4), DATA_W/ADDR_W
//   defaults, MAX_WAIT_STATES=15 constant.
//  One sub-module: mem_wait_counter (load, decrement, done flag) instantiated once; FSM and latches inline.
// TESTING
//  Reset held low 3 cycles mid-WAIT of a read -> all outputs 0, no sram_en pulse, state IDLE after release.
//  WAIT_STATES=1: SRAM[0x010]=0xBEEF, MemRead Addr=0x0010 at cycle 0 -> sram_en cycle 2, MemReady & ReadData=0xBEEF cycle 3.
//  WAIT_STATES=0: MemWrite Addr=0x0020 WriteData=0x1234 -> sram_en&sram_we cycle 1, MemReady cycle 2; readback=0x1234.
//  MemRead&MemWrite together -> MemReady&MemError at cycle 1, no sram_en, ReadData unchanged.
//  MemRead Addr=0x0400 (MEM_WORDS=1024) -> MemError at cycle 1; Addr=0x03FF reads normally.
//  Request toggled during WAIT -> ignored; back-to-back reads held high -> second accepted in IDLE after MemReady.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, parameter
// defaults and wait-state counter sizing.
package mem_resp_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 16;
  localparam int MEM_WORDS_DEF   = 1024;
  localparam int WAIT_STATES_DEF = 1;
  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loaded on request accept, decremented while the
// responder sits in WAIT; done flags the last wait cycle.
module mem_wait_counter
  import mem_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write at a time, inserts programmable
// wait states, drives a synchronous single-port SRAM and returns a completion strobe.
//
// state  | meaning
// IDLE   | waiting for MemRead xor MemWrite
// WAIT   | burning WAIT_STATES cycles before the SRAM access
// ACCESS | sram_en asserted for exactly one cycle
// RESP   | MemReady strobe, read data presented
// ERR    | MemReady + MemError strobe, no SRAM access
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_WORDS   = MEM_WORDS_DEF,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            Addr,
  input  logic [DATA_W-1:0]            WriteData,
  output logic [DATA_W-1:0]            ReadData,
  output logic                         MemReady,
  output logic                         MemError,
  output logic                         MemBusy,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [DATA_W-1:0]            sram_wdata,
  input  logic [DATA_W-1:0]            sram_rdata
);

  localparam int SA_W = $clog2(MEM_WORDS);

  state_t            state;
  state_t            state_nx;

  logic              op_wr;
  logic [SA_W-1:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              op_wr_d;
  logic [SA_W-1:0]   addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              en_d;
  logic              we_d;
  logic              ready_d;
  logic              error_d;
  logic              busy_d;
  logic              capture;

  logic              req_any;
  logic              in_range;
  logic              accept;
  logic              cnt_done;

  // Range check uses the full datapath address; the SRAM only sees the low bits.
  assign req_any  = MemRead | MemWrite;
  assign in_range = (32'(Addr) < 32'(MEM_WORDS));
  assign accept   = (state == ST_IDLE) && (MemRead ^ MemWrite) && in_range;

  mem_wait_counter u_wait_counter (
    .clk      (CLK),
    .rst_b    (Reset),
    .load     (accept),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (state == ST_WAIT),
    .done     (cnt_done)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end else if (req_any) begin
          state_nx = ST_ERR;
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state; with zero wait states the access
  // happens on the cycle after accept, so the latch contents are bypassed.
  always_comb begin
    op_wr_d = op_wr;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      op_wr_d = MemWrite;
      addr_d  = Addr[SA_W-1:0];
      wdata_d = WriteData;
    end
    en_d    = (state_nx == ST_ACCESS);
    we_d    = en_d & op_wr_d;
    ready_d = (state_nx == ST_RESP) || (state_nx == ST_ERR);
    error_d = (state_nx == ST_ERR);
    busy_d  = (state_nx != ST_IDLE);
    capture = (state == ST_RESP) && !op_wr;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      op_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      MemReady   <= 1'b0;
      MemError   <= 1'b0;
      MemBusy    <= 1'b0;
    end else begin
      op_wr    <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sram_en  <= en_d;
      sram_we  <= we_d;
      MemReady <= ready_d;
      MemError <= error_d;
      MemBusy  <= busy_d;
      if (en_d) begin
        sram_addr  <= addr_d;
        sram_wdata <= wdata_d;
      end
      if (capture) begin
        rdata_q <= sram_rdata;
      end
    end
  end

  // SRAM data arrives in the RESP cycle itself, so it is forwarded alongside
  // MemReady and held in rdata_q from the following cycle on.
  assign ReadData = capture ? sram_rdata : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (1, 0 and 5 wait states) with
// behavioural SRAMs, a directed vector table and randomized model-checked traffic.
module tb_mem_responder;

  localparam int N = 3;

  typedef struct {
    int          lat;
    int          en_n;
    int          en_cyc;
    logic        en_w;
    logic        e;
    logic [15:0] rd_at;
    logic        b_at;
    logic [15:0] rd_after;
    logic        b_after;
  } res_t;

  typedef struct {
    int          k;
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        e;
    int          lat;
    int          en;
    logic [15:0] rdv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset  [N];
  logic        rd     [N];
  logic        wr     [N];
  logic [15:0] addr   [N];
  logic [15:0] wdata  [N];
  logic [15:0] rdata  [N];
  logic        ready  [N];
  logic        err    [N];
  logic        busy   [N];
  logic        en     [N];
  logic        we     [N];
  logic [9:0]  saddr  [N];
  logic [15:0] swdata [N];
  logic [15:0] srdata [N];

  logic [15:0] sram  [N][1024];
  logic [15:0] m_mem [N][1024];
  logic [15:0] m_rd  [N];
  logic [15:0] pool  [8];
  vec_t        vt    [13];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .Reset(reset[0]), .MemRead(rd[0]), .MemWrite(wr[0]), .Addr(addr[0]),
    .WriteData(wdata[0]), .ReadData(rdata[0]), .MemReady(ready[0]), .MemError(err[0]),
    .MemBusy(busy[0]), .sram_en(en[0]), .sram_we(we[0]), .sram_addr(saddr[0]),
    .sram_wdata(swdata[0]), .sram_rdata(srdata[0]));

  mem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_WORDS(1024), .WAIT_STATES(1)) dut1 (
    .CLK(clk), .Reset(reset[1]), .MemRead(rd[1]), .MemWrite(wr[1]), .Addr(addr[1]),
    .WriteData(wdata[1]), .ReadData(rdata[1]), .MemReady(ready[1]), .MemError(err[1]),
    .MemBusy(busy[1]), .sram_en(en[1]), .sram_we(we[1]), .sram_addr(saddr[1]),
    .sram_wdata(swdata[1]), .sram_rdata(srdata[1]));

  mem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_WORDS(1024), .WAIT_STATES(5)) dut2 (
    .CLK(clk), .Reset(reset[2]), .MemRead(rd[2]), .MemWrite(wr[2]), .Addr(addr[2]),
    .WriteData(wdata[2]), .ReadData(rdata[2]), .MemReady(ready[2]), .MemError(err[2]),
    .MemBusy(busy[2]), .sram_en(en[2]), .sram_we(we[2]), .sram_addr(saddr[2]),
    .sram_wdata(swdata[2]), .sram_rdata(srdata[2]));

  // Synchronous single-port SRAMs: read data valid the cycle after the enable.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (en[k]) begin
        if (we[k]) sram[k][saddr[k]] <= swdata[k];
        else       srdata[k] <= sram[k][saddr[k]];
      end
    end
  end

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic vec_t mkv(input int k, input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic e, input int lat, input int en_n,
                               input logic [15:0] rdv);
    vec_t v;
    v.k = k; v.r = r; v.w = w; v.a = a; v.d = d; v.e = e; v.lat = lat; v.en = en_n; v.rdv = rdv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Spec-level model: a legal read returns the last value written, writes update memory.
  task automatic model_apply(input int k, input logic r, input logic w, input logic [15:0] a,
                             input logic [15:0] d);
    if (!(r && w) && (a < 16'd1024)) begin
      if (r)      m_rd[k] = m_mem[k][a[9:0]];
      else if (w) m_mem[k][a[9:0]] = d;
    end
  endtask

  task automatic do_txn(input int k, input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit noise, output res_t res);
    @(posedge clk);
    #1;
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    res.lat = 0; res.en_n = 0; res.en_cyc = -1; res.en_w = 1'b0;
    @(negedge clk);
    while (!ready[k] && res.lat < 40) begin
      if (en[k]) begin
        res.en_n++;
        res.en_cyc = res.lat;
        res.en_w = we[k];
      end
      if (noise && res.lat > 0) begin
        rd[k] = 1'($urandom_range(0, 1));
        wr[k] = 1'($urandom_range(0, 1));
        addr[k] = 16'($urandom);
        wdata[k] = 16'($urandom);
      end
      res.lat++;
      @(negedge clk);
    end
    if (en[k]) res.en_n++;
    res.e = err[k];
    res.rd_at = rdata[k];
    res.b_at = busy[k];
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(negedge clk);
    if (en[k]) res.en_n++;
    res.rd_after = rdata[k];
    res.b_after = busy[k];
  endtask

  task automatic check_res(input string tag, input res_t res, input logic exp_e, input int exp_lat,
                           input int exp_en, input logic exp_we, input logic [15:0] exp_rd);
    chk({tag, " latency"}, 64'(res.lat), 64'(exp_lat));
    chk({tag, " MemError"}, 64'(res.e), 64'(exp_e));
    chk({tag, " ReadData@ready"}, 64'(res.rd_at), 64'(exp_rd));
    chk({tag, " ReadData hold"}, 64'(res.rd_after), 64'(exp_rd));
    chk({tag, " sram_en count"}, 64'(res.en_n), 64'(exp_en));
    chk({tag, " busy@ready"}, 64'(res.b_at), 64'(1));
    chk({tag, " busy after"}, 64'(res.b_after), 64'(0));
    if (exp_en != 0) begin
      chk({tag, " sram_en cycle"}, 64'(res.en_cyc), 64'(exp_lat - 1));
      chk({tag, " sram_we"}, 64'(res.en_w), 64'(exp_we));
    end
  endtask

  task automatic run_model_txn(input int k, input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input bit noise, input string tag);
    res_t res;
    logic illegal;
    illegal = (r && w) || (a >= 16'd1024);
    model_apply(k, r, w, a, d);
    do_txn(k, r, w, a, d, noise, res);
    check_res(tag, res, illegal, illegal ? 1 : ws_of(k) + 2, illegal ? 0 : 1, w, m_rd[k]);
  endtask

  initial begin
    res_t        res;
    int          cyc, nr, c1, c2, en_seen, rdy_seen;
    int          sel;
    logic        r, w;
    logic [15:0] a, d;

    vt[0]  = mkv(1, 0, 1, 16'h0010, 16'hBEEF, 0, 3, 1, 16'h0000);
    vt[1]  = mkv(1, 1, 0, 16'h0010, 16'h0000, 0, 3, 1, 16'hBEEF);
    vt[2]  = mkv(1, 1, 1, 16'h0010, 16'h1111, 1, 1, 0, 16'hBEEF);
    vt[3]  = mkv(1, 1, 0, 16'h0400, 16'h0000, 1, 1, 0, 16'hBEEF);
    vt[4]  = mkv(1, 0, 1, 16'h03FF, 16'h5A5A, 0, 3, 1, 16'hBEEF);
    vt[5]  = mkv(1, 1, 0, 16'h03FF, 16'h0000, 0, 3, 1, 16'h5A5A);
    vt[6]  = mkv(1, 0, 1, 16'hFFFF, 16'h0001, 1, 1, 0, 16'h5A5A);
    vt[7]  = mkv(1, 1, 0, 16'h0010, 16'h0000, 0, 3, 1, 16'hBEEF);
    vt[8]  = mkv(0, 0, 1, 16'h0020, 16'h1234, 0, 2, 1, 16'h0000);
    vt[9]  = mkv(0, 1, 0, 16'h0020, 16'h0000, 0, 2, 1, 16'h1234);
    vt[10] = mkv(0, 1, 0, 16'h0420, 16'h0000, 1, 1, 0, 16'h1234);
    vt[11] = mkv(2, 0, 1, 16'h0155, 16'hC0DE, 0, 7, 1, 16'h0000);
    vt[12] = mkv(2, 1, 0, 16'h0155, 16'h0000, 0, 7, 1, 16'hC0DE);

    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0010; pool[3] = 16'h0155;
    pool[4] = 16'h0200; pool[5] = 16'h02AA; pool[6] = 16'h03FE; pool[7] = 16'h03FF;

    for (int k = 0; k < N; k++) begin
      reset[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      m_rd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) reset[k] = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset k%0d MemReady", k), 64'(ready[k]), 64'(0));
      chk($sformatf("reset k%0d MemError", k), 64'(err[k]), 64'(0));
      chk($sformatf("reset k%0d MemBusy", k), 64'(busy[k]), 64'(0));
      chk($sformatf("reset k%0d sram_en", k), 64'(en[k]), 64'(0));
      chk($sformatf("reset k%0d sram_we", k), 64'(we[k]), 64'(0));
      chk($sformatf("reset k%0d sram_addr", k), 64'(saddr[k]), 64'(0));
      chk($sformatf("reset k%0d sram_wdata", k), 64'(swdata[k]), 64'(0));
      chk($sformatf("reset k%0d ReadData", k), 64'(rdata[k]), 64'(0));
    end

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d MemReady", c), 64'(ready[1]), 64'(0));
      chk($sformatf("idle c%0d MemBusy", c), 64'(busy[1]), 64'(0));
    end

    for (int i = 0; i < 13; i++) begin
      do_txn(vt[i].k, vt[i].r, vt[i].w, vt[i].a, vt[i].d, 1'b0, res);
      check_res($sformatf("vec%0d", i), res, vt[i].e, vt[i].lat, vt[i].en, vt[i].w, vt[i].rdv);
      model_apply(vt[i].k, vt[i].r, vt[i].w, vt[i].a, vt[i].d);
    end

    // Reset held low for three cycles while a read sits in WAIT.
    @(posedge clk);
    #1;
    rd[2] = 1'b1; addr[2] = 16'h0155;
    @(negedge clk);
    @(negedge clk);
    chk("rstwait busy before", 64'(busy[2]), 64'(1));
    reset[2] = 1'b0; rd[2] = 1'b0;
    en_seen = 0; rdy_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (en[2]) en_seen++;
      chk($sformatf("rstwait c%0d MemBusy", c), 64'(busy[2]), 64'(0));
      chk($sformatf("rstwait c%0d MemReady", c), 64'(ready[2]), 64'(0));
      chk($sformatf("rstwait c%0d sram_addr", c), 64'(saddr[2]), 64'(0));
      chk($sformatf("rstwait c%0d sram_wdata", c), 64'(swdata[2]), 64'(0));
      chk($sformatf("rstwait c%0d ReadData", c), 64'(rdata[2]), 64'(0));
    end
    reset[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (en[2]) en_seen++;
      if (ready[2] || busy[2]) rdy_seen++;
    end
    chk("rstwait sram_en pulses", 64'(en_seen), 64'(0));
    chk("rstwait activity after release", 64'(rdy_seen), 64'(0));
    m_rd[2] = '0;
    run_model_txn(2, 1'b1, 1'b0, 16'h0155, 16'h0000, 1'b0, "rstwait readback");

    // Request lines wiggled while the read is in flight must be ignored.
    run_model_txn(2, 1'b1, 1'b0, 16'h0155, 16'h0000, 1'b1, "noise k2");
    run_model_txn(1, 1'b0, 1'b1, 16'h03FE, 16'h7E57, 1'b1, "noise k1");

    // Read held high through completion: a second read follows one IDLE cycle later.
    @(posedge clk);
    #1;
    rd[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0010;
    cyc = 0; nr = 0; c1 = -1; c2 = -1;
    while (nr < 2 && cyc < 40) begin
      @(negedge clk);
      if (ready[1]) begin
        if (nr == 0) c1 = cyc;
        else         c2 = cyc;
        nr++;
        chk($sformatf("b2b ready%0d ReadData", nr), 64'(rdata[1]), 64'(m_mem[1][10'h010]));
      end
      cyc++;
    end
    rd[1] = 1'b0;
    chk("b2b first ready cycle", 64'(c1), 64'(ws_of(1) + 2));
    chk("b2b second ready cycle", 64'(c2), 64'(2 * (ws_of(1) + 2) + 1));
    rdy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready[1]) rdy_seen++;
    end
    chk("b2b no third completion", 64'(rdy_seen), 64'(0));
    m_rd[1] = m_mem[1][10'h010];

    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 8; p++) begin
        run_model_txn(k, 1'b0, 1'b1, pool[p], 16'($urandom), 1'b0, $sformatf("fill k%0d p%0d", k, p));
      end
      for (int t = 0; t < 40; t++) begin
        sel = int'($urandom_range(0, 9));
        a = pool[$urandom_range(0, 7)];
        d = 16'($urandom);
        r = 1'b0; w = 1'b0;
        case (sel)
          0, 1, 2, 3: r = 1'b1;
          4, 5, 6:    w = 1'b1;
          7:          begin r = 1'b1; w = 1'b1; end
          8:          begin r = 1'b1; a = 16'($urandom_range(1024, 65535)); end
          default:    begin w = 1'b1; a = 16'($urandom_range(1024, 65535)); end
        endcase
        run_model_txn(k, r, w, a, d, 1'($urandom_range(0, 1)), $sformatf("rand k%0d t%0d", k, t));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
